// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - producer write port and UART handshake bundle for uart_tx_fifo
// Optional member cts_n exists only when UART_TX_FIFO_CTS_EN is defined.
interface uart_tx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   level;
  logic                  overflow;
  logic                  overflow_clr;
  logic                  uart_enable;
  logic [DATA_WIDTH-1:0] uart_data;
  logic                  uart_busy;
`ifdef UART_TX_FIFO_CTS_EN
  logic                  cts_n;
`endif

  // Environment side: producer plus UART transmitter.
  modport master (
`ifdef UART_TX_FIFO_CTS_EN
    output cts_n,
`endif
    output wr_en, wr_data, overflow_clr, uart_busy,
    input  full, empty, level, overflow, uart_enable, uart_data
  );

  // FIFO side.
  modport slave (
`ifdef UART_TX_FIFO_CTS_EN
    input  cts_n,
`endif
    input  wr_en, wr_data, overflow_clr, uart_busy,
    output full, empty, level, overflow, uart_enable, uart_data
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - circular byte FIFO feeding a UART transmitter's enable/data/busy handshake
// Optional clear-to-send gating (cts_n) is enabled by defining UART_TX_FIFO_CTS_EN.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input logic           clk,
  input logic           reset,
  uart_tx_fifo_if.slave bus
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] LEVEL_FULL = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   level;
  logic                  overflow;
  logic                  uart_enable;
  logic                  enable_next;
  logic [DATA_WIDTH-1:0] uart_data;
  logic                  full;
  logic                  empty;
  logic                  clear_to_send;
  logic                  pop;
  logic                  push;
  logic                  overflow_set;

  assign full  = (level == LEVEL_FULL);
  assign empty = (level == '0);

`ifdef UART_TX_FIFO_CTS_EN
  assign clear_to_send = ~bus.cts_n;
`else
  assign clear_to_send = 1'b1;
`endif

  // A write while full is still accepted when a pop frees the slot on the same edge.
  assign push         = bus.wr_en & (~full | pop);
  assign overflow_set = bus.wr_en & full & ~pop;

  // Storage array: contents need no reset, validity is tracked by level.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  // Pointers and occupancy counter; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Sticky overflow flag; a new overflow beats a clear in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (overflow_set) begin
      overflow <= 1'b1;
    end else if (bus.overflow_clr) begin
      overflow <= 1'b0;
    end
  end

  // Handshake state, launch pulse and the byte held for the whole frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      uart_enable <= 1'b0;
      uart_data   <= '0;
    end else begin
      state       <= state_next;
      uart_enable <= enable_next;
      if (pop) uart_data <= mem[rd_ptr];
    end
  end

  // Next-state decode; a pop only ever happens on the IDLE->LAUNCH edge.
  always_comb begin
    state_next  = state;
    enable_next = 1'b0;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !bus.uart_busy && clear_to_send) begin
          pop         = 1'b1;
          enable_next = 1'b1;
          state_next  = LAUNCH;
        end
      end
      LAUNCH:    state_next = WAIT_BUSY;
      WAIT_BUSY: if (bus.uart_busy)  state_next = WAIT_DONE;
      WAIT_DONE: if (!bus.uart_busy) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.level       = level;
  assign bus.overflow    = overflow;
  assign bus.uart_enable = uart_enable;
  assign bus.uart_data   = uart_data;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
// Exercises the cts_n path only when UART_TX_FIFO_CTS_EN is defined.
module tb_uart_tx_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  int         checks = 0;
  int         errors = 0;
  int         pulses = 0;
  int         busy_viol = 0;
  int         long_pulse = 0;
  int         base = 0;
  int         cnt = 0;
  logic       prev_en = 1'b0;
  logic [7:0] sent [$];

  uart_tx_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Record every launch pulse and flag pulses that overlap busy or last more than a cycle.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.uart_enable) begin
        pulses++;
        sent.push_back(bus.uart_data);
        if (bus.uart_busy) busy_viol++;
        if (prev_en) long_pulse++;
      end
      prev_en = bus.uart_enable;
    end else begin
      prev_en = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write(input logic [7:0] b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    tick(1);
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_enable(input string tag);
    for (int i = 0; i < 300 && !bus.uart_enable; i++) tick(1);
    check({tag, " launch"}, 32'(bus.uart_enable), 32'd1);
  endtask

  task automatic frame(input string tag);
    wait_enable(tag);
    tick(2);
    bus.uart_busy = 1'b1;
    tick(10);
    bus.uart_busy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.wr_en        = 1'b0;
    bus.wr_data      = '0;
    bus.overflow_clr = 1'b0;
    bus.uart_busy    = 1'b0;
`ifdef UART_TX_FIFO_CTS_EN
    bus.cts_n        = 1'b0;
`endif

    // Reset state and idle run
    tick(3);
    check("rst empty", 32'(bus.empty), 32'd1);
    check("rst full", 32'(bus.full), 32'd0);
    check("rst level", 32'(bus.level), 32'd0);
    check("rst enable", 32'(bus.uart_enable), 32'd0);
    reset = 1'b1;
    tick(100);
    check("idle empty", 32'(bus.empty), 32'd1);
    check("idle level", 32'(bus.level), 32'd0);
    check("idle data", 32'(bus.uart_data), 32'd0);
    check("idle overflow", 32'(bus.overflow), 32'd0);
    check("idle pulses", 32'(pulses), 32'd0);

    // Single byte: enable one cycle after the write is sampled
    write(8'hA5);
    check("single level N", 32'(bus.level), 32'd1);
    check("single enable N", 32'(bus.uart_enable), 32'd0);
    tick(1);
    check("single enable N+1", 32'(bus.uart_enable), 32'd1);
    check("single data N+1", 32'(bus.uart_data), 32'hA5);
    check("single level N+1", 32'(bus.level), 32'd0);
    tick(1);
    check("single enable N+2", 32'(bus.uart_enable), 32'd0);
    tick(5);
    bus.uart_busy = 1'b1;
    tick(80);
    check("single data busy", 32'(bus.uart_data), 32'hA5);
    bus.uart_busy = 1'b0;
    tick(20);
    check("single data after", 32'(bus.uart_data), 32'hA5);
    check("single pulses", 32'(pulses), 32'd1);

    // Burst of 20 with pointer wrap and overflow
    bus.uart_busy = 1'b1;
    for (int i = 0; i < 16; i++) write(8'(i));
    check("burst level", 32'(bus.level), 32'd16);
    check("burst full", 32'(bus.full), 32'd1);
    check("burst ovf before", 32'(bus.overflow), 32'd0);
    write(8'h10);
    check("burst ovf 17th", 32'(bus.overflow), 32'd1);
    check("burst level 17th", 32'(bus.level), 32'd16);
    write(8'h11);
    write(8'h12);
    bus.overflow_clr = 1'b1;
    write(8'h13);
    bus.overflow_clr = 1'b0;
    check("ovf set beats clr", 32'(bus.overflow), 32'd1);
    bus.overflow_clr = 1'b1;
    tick(1);
    bus.overflow_clr = 1'b0;
    check("ovf cleared", 32'(bus.overflow), 32'd0);
    check("burst held", 32'(pulses), 32'd1);
    base = sent.size();
    bus.uart_busy = 1'b0;
    for (int i = 0; i < 16; i++) frame("burst");
    tick(30);
    check("burst count", 32'(sent.size() - base), 32'd16);
    for (int i = 0; i < 16; i++) check($sformatf("burst byte %0d", i), 32'(sent[base + i]), 32'(i));
    check("burst drained", 32'(bus.empty), 32'd1);

    // Simultaneous write and pop while full
    bus.uart_busy = 1'b1;
    for (int i = 0; i < 16; i++) write(8'(8'h20 + i));
    check("simul full", 32'(bus.full), 32'd1);
    base = sent.size();
    bus.uart_busy = 1'b0;
    bus.wr_en     = 1'b1;
    bus.wr_data   = 8'h55;
    tick(1);
    bus.wr_en     = 1'b0;
    check("simul level", 32'(bus.level), 32'd16);
    check("simul ovf", 32'(bus.overflow), 32'd0);
    check("simul enable", 32'(bus.uart_enable), 32'd1);
    check("simul data", 32'(bus.uart_data), 32'h20);
    for (int i = 0; i < 17; i++) frame("simul");
    tick(30);
    check("simul count", 32'(sent.size() - base), 32'd17);
    check("simul last", 32'(sent[base + 16]), 32'h55);
    check("simul drained", 32'(bus.level), 32'd0);

    // Reset during WAIT_DONE with 5 bytes queued
    bus.uart_busy = 1'b1;
    for (int i = 0; i < 6; i++) write(8'(8'h61 + i));
    bus.uart_busy = 1'b0;
    wait_enable("rst mid");
    tick(2);
    bus.uart_busy = 1'b1;
    tick(3);
    check("mid queued", 32'(bus.level), 32'd5);
    #2;
    reset = 1'b0;
    #1;
    check("mid enable", 32'(bus.uart_enable), 32'd0);
    check("mid data", 32'(bus.uart_data), 32'd0);
    check("mid level", 32'(bus.level), 32'd0);
    check("mid empty", 32'(bus.empty), 32'd1);
    tick(2);
    reset = 1'b1;
    bus.uart_busy = 1'b0;
    cnt = pulses;
    tick(50);
    check("mid silent", 32'(pulses), 32'(cnt));
    write(8'h77);
    frame("post rst");
    tick(20);
    check("post rst byte", 32'(sent[$]), 32'h77);

`ifdef UART_TX_FIFO_CTS_EN
    // Clear-to-send holds the byte until cts_n falls
    bus.cts_n = 1'b1;
    cnt = pulses;
    write(8'h3C);
    tick(50);
    check("cts held", 32'(pulses), 32'(cnt));
    check("cts level", 32'(bus.level), 32'd1);
    bus.cts_n = 1'b0;
    tick(1);
    check("cts enable", 32'(bus.uart_enable), 32'd1);
    check("cts data", 32'(bus.uart_data), 32'h3C);
    frame("cts");
    tick(20);
`endif

    check("enable vs busy", 32'(busy_viol), 32'd0);
    check("pulse width", 32'(long_pulse), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit-side buffer that sits directly upstream of the UART transmitter.
- Accepts bytes from a producer through a write-enable interface and stores them in a circular FIFO.
- Drives the transmitter's enable / i_data / o_busy handshake so bytes go out back-to-back.
- Meets the transmitter's rules: enable only while not busy, and i_data held stable for the whole frame.

Parameters:
- DATA_WIDTH, 8: byte width; must match the UART INPUT_DATA_WIDTH.
- DEPTH, 16: number of FIFO entries; must be a power of two, minimum 2.
- ADDR_WIDTH, $clog2(DEPTH): pointer width; derived, do not override.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- wr_en  input  1  producer write strobe.
- wr_data  input  DATA_WIDTH  byte to enqueue.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- level  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was attempted while full.
- overflow_clr  input  1  synchronous clear of overflow.
- uart_enable  output  1  one-cycle start pulse to the UART enable input.
- uart_data  output  DATA_WIDTH  byte to the UART i_data input.
- uart_busy  input  1  UART o_busy.

Behaviour:
- Reset (reset==0, asynchronous):
  - pointers=0, level=0, empty=1, full=0, overflow=0.
  - uart_enable=0, uart_data=0, state=IDLE.
  - Reset asserted mid-frame discards the FIFO contents and the in-flight byte.
- Storage and pointers:
  - Registered array of DEPTH entries.
  - wr_ptr and rd_ptr are ADDR_WIDTH bits wide and wrap modulo DEPTH.
  - level is a separate counter.
  - full = (level==DEPTH); empty = (level==0). Both are combinational from level.
- Write:
  - wr_en && !full: store wr_data at wr_ptr, advance wr_ptr, level+1.
  - wr_en && full: the write is dropped, overflow<=1, and no pointer or level changes.
- overflow:
  - overflow_clr clears it.
  - If overflow_clr and a new overflow occur in the same cycle, the set wins.
- Pop: happens only in the IDLE->LAUNCH transition. Reads the entry at rd_ptr into the uart_data register, advances rd_ptr, level-1.
- Simultaneous write and pop: level unchanged and both pointers advance. This is legal even when full, because the pop frees the slot in the same edge and the write is accepted, with no overflow. When empty, a write cannot be popped in the same cycle.
- Handshake FSM:
  - IDLE: if level!=0 && !uart_busy, pop, uart_enable<=1, go to LAUNCH. Otherwise stay.
  - LAUNCH (1 cycle): uart_enable<=0, go to WAIT_BUSY.
  - WAIT_BUSY: stay until uart_busy==1, then go to WAIT_DONE. No timeout; the UART raises busy on its next baud tick.
  - WAIT_DONE: stay until uart_busy==0, then go to IDLE.
- uart_data is held unchanged from the pop until the next pop. It never changes while the state is anything other than IDLE.
- uart_enable is high for exactly one clock per byte and never high while uart_busy==1.
- Latency from a write into an empty FIFO while in IDLE:
  - wr_en sampled at edge N.
  - uart_enable=1 and uart_data valid after edge N+1.
  - uart_enable=0 after edge N+2.
- Minimum spacing between enable pulses is one full UART frame plus 3 clocks (LAUNCH, the IDLE re-check, and the pop).

Optional Feature:
- Macro: UART_TX_FIFO_CTS_EN.
- Defined: adds input port cts_n (1 bit, active-low clear-to-send, already synchronised by the integrator).
  - The IDLE->LAUNCH transition additionally requires cts_n==0.
  - A frame already launched always completes regardless of cts_n.
  - Bytes stay queued while cts_n==1.
- Not defined: the port is absent and the transition condition is as described above.

Test Plan:
- Reset then idle:
  - Release reset with no writes, run 100 clocks.
  - Required: empty=1, level=0, uart_enable never asserted, uart_data=0.
- Single byte:
  - Write 0xA5 at edge N with uart_busy=0.
  - Required: uart_enable=1 for one cycle after N+1, uart_data=0xA5, level back to 0.
  - Model busy rising 8 clocks later and falling 88 clocks later; uart_data stays 0xA5 throughout, and no second pulse occurs.
- Burst with wrap:
  - Write 0x00..0x13 (20 bytes, DEPTH=16) while the UART model is busy.
  - Required: 16 accepted, full=1, overflow=1 after the 17th write.
  - Bytes 0x00..0x0F are transmitted in order, uart_enable pulses once per frame, and the last 4 bytes are absent.
- Simultaneous write and pop at full:
  - Fill to 16, then drop busy so that a pop coincides with wr_en of 0x55.
  - Required: level stays 16, overflow unchanged, and 0x55 is transmitted last.
- Reset mid-frame:
  - Assert reset during WAIT_DONE with 5 bytes queued.
  - Required: outputs return immediately to reset values, level=0, and nothing is transmitted after release until a new write.
- CTS (UART_TX_FIFO_CTS_EN defined):
  - Queue 0x3C with cts_n=1 for 50 clocks, then set cts_n=0.
  - Required: no uart_enable while cts_n=1, and the pulse occurs 1 clock after cts_n falls.
